// File: rtl/issue_dispatch.sv
// Multi-lane rename-to-issue dispatch: routes ops by type into per-channel age-ordered
// buffers, tracks source readiness via completion broadcasts, and issues one op per channel.
module issue_dispatch #(
  parameter int LANES    = 4,
  parameter int NUM_CH   = 3,
  parameter int DEPTH    = 4,
  parameter int OP_W     = 64,
  parameter int TYPE_LSB = 45,
  parameter int TYPE_W   = 3,
  parameter int TAG_W    = 6,
  parameter int S0_LSB   = 0,
  parameter int S1_LSB   = 6,
  parameter int CMPLT_N  = 5,
  parameter logic [NUM_CH-1:0] OOO_MASK = {{(NUM_CH-1){1'b0}}, 1'b1},
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES*OP_W-1:0]     in_op,
  input  logic [2*LANES-1:0]        in_src_rdy,
  input  logic [LANES-1:0]          in_valid,
  output logic [LANES-1:0]          in_ready,
  input  logic [CMPLT_N*TAG_W-1:0]  cmplt_tag,
  input  logic [CMPLT_N-1:0]        cmplt_valid,
  input  logic                      flush,
  output logic [NUM_CH*OP_W-1:0]    dout,
  output logic [NUM_CH-1:0]         dout_valid,
  input  logic [NUM_CH-1:0]         dout_ready,
  output logic [NUM_CH*CW-1:0]      ch_count
);

  logic [OP_W-1:0] op_q [NUM_CH][DEPTH];
  logic [OP_W-1:0] op_d [NUM_CH][DEPTH];
  logic            r0_q [NUM_CH][DEPTH];
  logic            r0_d [NUM_CH][DEPTH];
  logic            r1_q [NUM_CH][DEPTH];
  logic            r1_d [NUM_CH][DEPTH];
  logic [CW-1:0]   cnt_q [NUM_CH];
  logic [CW-1:0]   cnt_d [NUM_CH];

  logic [LANES-1:0]  in_ready_s;
  logic [NUM_CH-1:0] push_s;
  logic [OP_W-1:0]   push_op_s [NUM_CH];
  logic              push_r0_s [NUM_CH];
  logic              push_r1_s [NUM_CH];
  logic [NUM_CH-1:0] issue_s;
  logic [NUM_CH-1:0] pop_s;
  int                sel_s [NUM_CH];

  function automatic logic woken(input logic [TAG_W-1:0] tag,
                                 input logic [CMPLT_N*TAG_W-1:0] ctag,
                                 input logic [CMPLT_N-1:0] cv);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < CMPLT_N; p++) begin
      hit = hit | (cv[p] & (ctag[p*TAG_W +: TAG_W] == tag));
    end
    return hit;
  endfunction

  // Out-of-range types fold into the last channel
  function automatic int route(input logic [TYPE_W-1:0] t);
    if (int'(t) < NUM_CH) begin
      return int'(t);
    end else begin
      return NUM_CH - 1;
    end
  endfunction

  // Lane acceptance: prefix mask, one op per channel, full judged on pre-pop count
  always_comb begin
    logic [NUM_CH-1:0] taken;
    logic              blocked;
    logic [TAG_W-1:0]  t0;
    logic [TAG_W-1:0]  t1;
    int                ch;
    taken      = '0;
    blocked    = 1'b0;
    in_ready_s = '0;
    push_s     = '0;
    t0         = '0;
    t1         = '0;
    ch         = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      push_op_s[c] = '0;
      push_r0_s[c] = 1'b0;
      push_r1_s[c] = 1'b0;
    end
    for (int i = 0; i < LANES; i++) begin
      ch = route(in_op[i*OP_W+TYPE_LSB +: TYPE_W]);
      t0 = in_op[i*OP_W+S0_LSB +: TAG_W];
      t1 = in_op[i*OP_W+S1_LSB +: TAG_W];
      if (rst || flush || blocked || (cnt_q[ch] == CW'(DEPTH)) || taken[ch]) begin
        blocked = 1'b1;
      end else begin
        in_ready_s[i] = 1'b1;
        if (in_valid[i]) begin
          push_s[ch]    = 1'b1;
          push_op_s[ch] = in_op[i*OP_W +: OP_W];
          push_r0_s[ch] = in_src_rdy[2*i] | (t0 < TAG_W'(2)) | woken(t0, cmplt_tag, cmplt_valid);
          push_r1_s[ch] = in_src_rdy[2*i+1] | (t1 < TAG_W'(2)) | woken(t1, cmplt_tag, cmplt_valid);
        end else begin
          push_s[ch] = push_s[ch];
        end
      end
      taken[ch] = 1'b1;
    end
  end

  // Issue select from registered entries; descending scan leaves the oldest ready entry
  always_comb begin
    issue_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_s[c] = 0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if ((k < int'(cnt_q[c])) && r0_q[c][k] && r1_q[c][k] && (OOO_MASK[c] || (k == 0))) begin
          issue_s[c] = 1'b1;
          sel_s[c]   = k;
        end else begin
          issue_s[c] = issue_s[c];
        end
      end
    end
    if (rst || flush) begin
      issue_s = '0;
    end else begin
      issue_s = issue_s;
    end
    pop_s = issue_s & dout_ready;
  end

  // Next buffer state: compact over the popped slot, append push, apply wakeups
  always_comb begin
    int src;
    int widx;
    src  = 0;
    widx = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      widx = int'(cnt_q[c]) - (pop_s[c] ? 1 : 0);
      for (int k = 0; k < DEPTH; k++) begin
        if (pop_s[c] && (k >= sel_s[c]) && (k < DEPTH - 1)) begin
          src = k + 1;
        end else begin
          src = k;
        end
        op_d[c][k] = op_q[c][src];
        r0_d[c][k] = r0_q[c][src] | woken(op_q[c][src][S0_LSB +: TAG_W], cmplt_tag, cmplt_valid);
        r1_d[c][k] = r1_q[c][src] | woken(op_q[c][src][S1_LSB +: TAG_W], cmplt_tag, cmplt_valid);
        if (push_s[c] && (k == widx)) begin
          op_d[c][k] = push_op_s[c];
          r0_d[c][k] = push_r0_s[c];
          r1_d[c][k] = push_r1_s[c];
        end else begin
          op_d[c][k] = op_d[c][k];
        end
      end
      if (flush) begin
        cnt_d[c] = '0;
      end else begin
        cnt_d[c] = cnt_q[c] + CW'(push_s[c]) - CW'(pop_s[c]);
      end
    end
  end

  // Buffer state registers; payload needs no reset since count gates validity
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        cnt_q[c] <= '0;
      end else begin
        cnt_q[c] <= cnt_d[c];
      end
      for (int k = 0; k < DEPTH; k++) begin
        op_q[c][k] <= op_d[c][k];
        r0_q[c][k] <= r0_d[c][k];
        r1_q[c][k] <= r1_d[c][k];
      end
    end
  end

  // Output packing
  always_comb begin
    in_ready   = in_ready_s;
    dout_valid = issue_s;
    for (int c = 0; c < NUM_CH; c++) begin
      dout[c*OP_W +: OP_W]  = op_q[c][sel_s[c]];
      ch_count[c*CW +: CW]  = cnt_q[c];
    end
  end

endmodule

// File: doc/issue_dispatch.md
ISSUE_DISPATCH -- requirements
Module: issue_dispatch

Interface
REQ-001 SHALL have parameter LANES, default 4: number of input op lanes per cycle.
REQ-002 SHALL have parameter NUM_CH, default 3: number of issue channels.
REQ-003 SHALL have parameter DEPTH, default 4: entries per channel buffer, DEPTH>=2.
REQ-004 SHALL have parameter OP_W, default 64: renamed op width.
REQ-005 SHALL have parameters TYPE_LSB=45 and TYPE_W=3: position and width of the op type field.
REQ-006 SHALL have parameters TAG_W=6, S0_LSB=0 and S1_LSB=6: physical source tag width and field positions.
REQ-007 SHALL have parameter CMPLT_N, default 5: completion broadcast ports.
REQ-008 SHALL have parameter OOO_MASK, default 'b001: bit c=1 makes channel c out-of-order, 0 makes it in-order.
REQ-009 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-010 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-011 SHALL have port in_op, input, LANES*OP_W bits: ops, lane 0 oldest.
REQ-012 SHALL have port in_src_rdy, input, 2*LANES bits: per lane {src1,src0} already-ready at rename.
REQ-013 SHALL have port in_valid, input, LANES bits: valid per lane, contiguous from lane 0.
REQ-014 SHALL have port in_ready, output, LANES bits: lane accepted when in_valid[i]&in_ready[i].
REQ-015 SHALL have ports cmplt_tag (input, CMPLT_N*TAG_W bits) and cmplt_valid (input, CMPLT_N bits): tag wakeup broadcast.
REQ-016 SHALL have port flush, input, 1 bit: discard all buffered ops.
REQ-017 SHALL have ports dout (output, NUM_CH*OP_W bits), dout_valid (output, NUM_CH bits) and dout_ready (input, NUM_CH bits): per-channel issue.
REQ-018 SHALL have port ch_count, output, NUM_CH*$clog2(DEPTH+1) bits: per-channel occupancy.

Function
REQ-019 SHALL route each op to channel = type field if type<NUM_CH, else NUM_CH-1.
REQ-020 SHALL accept at most one op per channel per cycle.
REQ-021 SHALL make in_ready a prefix mask: in_ready[i]=1 only if every lane j<=i maps to a channel that is not full and is not targeted by any lower lane j<i; lanes above the first blocked lane SHALL be 0.
REQ-022 SHALL treat a channel with count==DEPTH as full even when it pops in the same cycle, so there is no combinational path from dout_ready to in_ready.
REQ-023 SHALL store per entry src0/src1 ready bits, set at insertion from in_src_rdy, from tag<2 (always-ready), or from a same-cycle matching cmplt_valid tag.
REQ-024 SHALL set a stored src ready bit on the edge after a matching valid completion tag; ready bits SHALL never clear while the entry is resident.
REQ-025 SHALL keep each buffer age-ordered and compacting: index 0 oldest, and a removal SHALL shift younger entries down in the same edge.
REQ-026 SHALL, for an in-order channel, assert dout_valid only when entry 0 exists with both src bits ready, and dout SHALL be entry 0.
REQ-027 SHALL, for an out-of-order channel, select the lowest-index entry with both src bits ready.
REQ-028 SHALL drive dout_valid and dout from registered state only, so an op accepted at edge N is issuable at the earliest in the cycle after N.
REQ-029 SHALL remove the selected entry at an edge where dout_valid&dout_ready; on a simultaneous push to the same channel the new op SHALL land at index count-1.
REQ-030 SHALL update ch_count as count+push-pop each edge.
REQ-031 SHALL, while flush=1, force in_ready=0 and dout_valid=0, and empty all channels at that edge; flush SHALL override push and pop.
REQ-032 SHALL keep dout don't-care when dout_valid=0.

Reset
REQ-033 SHALL, at rst=1 at an edge, empty all channels; in the following cycle ch_count=0 and dout_valid=0.
REQ-034 SHALL, while rst=1, drive in_ready=0, with buffered content discarded even mid-operation.

Verification
REQ-035 SHALL cover: 4 lanes of types {0,1,7,0}, all srcs ready -> in_ready=4'b0111, ch_count={1,1,1}, every dout_valid=1 in the next cycle.
REQ-036 SHALL cover: channel 1 filled with DEPTH=4 ops and dout_ready[1]=1 -> in_ready[0]=0 for a type-1 lane during that cycle; accepted the next cycle.
REQ-037 SHALL cover: OoO channel 0 with entries A(src tag 9 not ready) and B(ready) -> B issues first; cmplt tag 9 -> A dout_valid one cycle later.
REQ-038 SHALL cover: in-order channel 2 with a head waiting on tag 12 and a ready younger entry -> dout_valid[2]=0 until tag 12 completes.
REQ-039 SHALL cover: an op with src tag 20 inserted while cmplt_tag=20 is valid in the same cycle -> issuable the next cycle.
REQ-040 SHALL cover: flush with 3 channels holding entries and pushes pending -> all ch_count=0 next cycle and no op issued or accepted during the flush cycle.
